rv32_datapath: RTL and testbench

- Single-cycle RV32I datapath: PC register, 32x32 register file, immediate generator, ALU, PC-relative adder, load extender and result/next-PC muxes.
- All control comes from an external controller/decoder. The block exposes instruction-fetch PC, data-memory address/store data, and ALU comparison flags that the controller uses to decide branches.

---
 rtl/rv32_pkg.sv | 34 +++
 rtl/rv32_regfile.sv | 44 ++++
 rtl/rv32_datapath.sv | 141 ++++++++++++++
 tb/tb_rv32_datapath.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared encodings for the RV32I single-cycle datapath and its register file.
package rv32_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALU     = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_PC4     = 2'b10;
  localparam logic [1:0] RES_IMMPLUS = 2'b11;

  localparam logic [1:0] PCSRC_PC4     = 2'b00;
  localparam logic [1:0] PCSRC_IMMPLUS = 2'b01;
  localparam logic [1:0] PCSRC_ALU     = 2'b10;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

endpackage

// File: rtl/rv32_regfile.sv
// 31 writable 32-bit registers with two combinational read ports; x0 reads zero.
module rv32_regfile
  import rv32_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_we,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);

  logic [31:0] regs_q [1:31];
  logic [31:0] regs_d [1:31];

  always_comb begin
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = regs_q[i];
      if (i_we && (i_rd == 5'(i))) regs_d[i] = i_wd;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Index 0 matches no entry, so x0 falls through to the zero default.
  always_comb begin
    o_rd1 = '0;
    o_rd2 = '0;
    for (int i = 1; i < 32; i++) begin
      if (i_rs1 == 5'(i)) o_rd1 = regs_q[i];
      if (i_rs2 == 5'(i)) o_rd2 = regs_q[i];
    end
  end

endmodule

// File: rtl/rv32_datapath.sv
// Single-cycle RV32I datapath: PC, register file, immediates, ALU, load/store lanes
// and write-back / next-PC selection, all steered by an external decoder.
module rv32_datapath
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_readData,
  input  logic [1:0]  i_memSize,
  input  logic        i_regWrite,
  input  logic [1:0]  i_PCSrc,
  input  logic        i_ALUSrc,
  input  logic [2:0]  i_immSrc,
  input  logic        i_immPlusSrc,
  input  logic        i_isLoadSigned,
  input  logic [1:0]  i_resultSrc,
  input  logic [3:0]  i_ALUCtrl,
  output logic [31:0] o_PC,
  output logic [31:0] o_ALUOut,
  output logic [31:0] o_writeData,
  output logic        o_zero,
  output logic        o_neg,
  output logic        o_negU
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] rs1_data, rs2_data, imm, alu_b, alu_out;
  logic [31:0] pc_plus4, imm_plus, load_data, result;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [1:0]  off;
  logic        unused_opcode;

  assign unused_opcode = ^i_inst[6:0];

  rv32_regfile u_regfile (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (i_regWrite),
    .i_rs1   (i_inst[19:15]),
    .i_rs2   (i_inst[24:20]),
    .i_rd    (i_inst[11:7]),
    .i_wd    (result),
    .o_rd1   (rs1_data),
    .o_rd2   (rs2_data)
  );

  always_comb begin
    imm = '0;
    case (i_immSrc)
      IMM_I: imm = {{20{i_inst[31]}}, i_inst[31:20]};
      IMM_S: imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      IMM_B: imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      IMM_U: imm = {i_inst[31:12], 12'b0};
      IMM_J: imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign alu_b = i_ALUSrc ? imm : rs2_data;

  always_comb begin
    alu_out = alu_b;
    case (i_ALUCtrl)
      ALU_ADD:  alu_out = rs1_data + alu_b;
      ALU_SUB:  alu_out = rs1_data - alu_b;
      ALU_AND:  alu_out = rs1_data & alu_b;
      ALU_OR:   alu_out = rs1_data | alu_b;
      ALU_XOR:  alu_out = rs1_data ^ alu_b;
      ALU_SLL:  alu_out = rs1_data << alu_b[4:0];
      ALU_SRL:  alu_out = rs1_data >> alu_b[4:0];
      ALU_SRA:  alu_out = 32'($signed(rs1_data) >>> alu_b[4:0]);
      ALU_SLT:  alu_out = {31'b0, $signed(rs1_data) < $signed(alu_b)};
      ALU_SLTU: alu_out = {31'b0, rs1_data < alu_b};
      default:  alu_out = alu_b;
    endcase
  end

  assign o_ALUOut = alu_out;
  assign o_zero   = (alu_out == 32'b0);
  assign o_neg    = $signed(rs1_data) < $signed(alu_b);
  assign o_negU   = rs1_data < alu_b;

  assign pc_plus4 = pc_q + 32'd4;
  assign imm_plus = (i_immPlusSrc ? 32'b0 : pc_q) + imm;

  // Memory returns the aligned word; the low address bits pick the lane.
  assign off     = alu_out[1:0];
  assign ld_byte = i_readData[{off, 3'b000} +: 8];
  assign ld_half = off[1] ? i_readData[31:16] : i_readData[15:0];

  always_comb begin
    load_data   = i_readData;
    o_writeData = rs2_data;
    case (i_memSize)
      MEM_B: begin
        load_data   = {{24{i_isLoadSigned & ld_byte[7]}}, ld_byte};
        o_writeData = {4{rs2_data[7:0]}};
      end
      MEM_H: begin
        load_data   = {{16{i_isLoadSigned & ld_half[15]}}, ld_half};
        o_writeData = {2{rs2_data[15:0]}};
      end
      default: begin
        load_data   = i_readData;
        o_writeData = rs2_data;
      end
    endcase
  end

  always_comb begin
    result = alu_out;
    case (i_resultSrc)
      RES_ALU:     result = alu_out;
      RES_MEM:     result = load_data;
      RES_PC4:     result = pc_plus4;
      RES_IMMPLUS: result = imm_plus;
      default:     result = alu_out;
    endcase
  end

  always_comb begin
    pc_d = pc_plus4;
    case (i_PCSrc)
      PCSRC_IMMPLUS: pc_d = imm_plus;
      PCSRC_ALU:     pc_d = {alu_out[31:1], 1'b0};
      default:       pc_d = pc_plus4;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) pc_q <= RESET_PC;
    else         pc_q <= pc_d;
  end

  assign o_PC = pc_q;

endmodule

// File: tb/tb_rv32_datapath.sv
// Directed-vector bench for rv32_datapath; register contents are observed by
// routing a register through an ADD with x0 onto o_ALUOut.
module tb_rv32_datapath;
  import rv32_pkg::*;

  logic        i_clk;
  logic        i_reset;
  logic [31:0] i_inst;
  logic [31:0] i_readData;
  logic [1:0]  i_memSize;
  logic        i_regWrite;
  logic [1:0]  i_PCSrc;
  logic        i_ALUSrc;
  logic [2:0]  i_immSrc;
  logic        i_immPlusSrc;
  logic        i_isLoadSigned;
  logic [1:0]  i_resultSrc;
  logic [3:0]  i_ALUCtrl;
  logic [31:0] o_PC;
  logic [31:0] o_ALUOut;
  logic [31:0] o_writeData;
  logic        o_zero;
  logic        o_neg;
  logic        o_negU;

  int total = 0;
  int bad   = 0;

  rv32_datapath dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_inst         (i_inst),
    .i_readData     (i_readData),
    .i_memSize      (i_memSize),
    .i_regWrite     (i_regWrite),
    .i_PCSrc        (i_PCSrc),
    .i_ALUSrc       (i_ALUSrc),
    .i_immSrc       (i_immSrc),
    .i_immPlusSrc   (i_immPlusSrc),
    .i_isLoadSigned (i_isLoadSigned),
    .i_resultSrc    (i_resultSrc),
    .i_ALUCtrl      (i_ALUCtrl),
    .o_PC           (o_PC),
    .o_ALUOut       (o_ALUOut),
    .o_writeData    (o_writeData),
    .o_zero         (o_zero),
    .o_neg          (o_neg),
    .o_negU         (o_negU)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      $display("check %s = %h", tag, obs);
    end else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    i_inst         = 32'h0;
    i_readData     = 32'h0;
    i_memSize      = MEM_W;
    i_regWrite     = 1'b0;
    i_PCSrc        = PCSRC_PC4;
    i_ALUSrc       = 1'b0;
    i_immSrc       = IMM_I;
    i_immPlusSrc   = 1'b0;
    i_isLoadSigned = 1'b0;
    i_resultSrc    = RES_ALU;
    i_ALUCtrl      = ALU_ADD;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // add x0, xr, x0 puts xr on o_ALUOut without writing anything.
  task automatic rdreg(input int r, input logic [31:0] exp, input string tag);
    idle();
    i_inst = {7'd0, 5'd0, 5'(r), 3'd0, 5'd0, 7'h33};
    #1;
    chk(tag, o_ALUOut, exp);
  endtask

  // I-type style step writing the selected result into rd.
  task automatic load_step(input logic [31:0] inst, input logic [1:0] size,
                           input logic sgn, input logic [31:0] rdata);
    idle();
    i_inst = inst; i_ALUSrc = 1'b1; i_immSrc = IMM_I; i_regWrite = 1'b1;
    i_resultSrc = RES_MEM; i_memSize = size; i_isLoadSigned = sgn; i_readData = rdata;
    tick();
  endtask

  logic [3:0]  ops  [12];
  logic [31:0] expv [12];

  initial begin
    ops[0] = ALU_ADD;  expv[0] = 32'hAABBCCE4;
    ops[1] = ALU_SUB;  expv[1] = 32'hAABBCCD6;
    ops[2] = ALU_AND;  expv[2] = 32'h00000005;
    ops[3] = ALU_OR;   expv[3] = 32'hAABBCCDF;
    ops[4] = ALU_XOR;  expv[4] = 32'hAABBCCDA;
    ops[5] = ALU_SLL;  expv[5] = 32'h5DE66E80;
    ops[6] = ALU_SRL;  expv[6] = 32'h01557799;
    ops[7] = ALU_SRA;  expv[7] = 32'hFF557799;
    ops[8] = ALU_SLT;  expv[8] = 32'h00000001;
    ops[9] = ALU_SLTU; expv[9] = 32'h00000000;
    ops[10] = 4'b1010; expv[10] = 32'h00000007;
    ops[11] = 4'b1111; expv[11] = 32'h00000007;

    idle();
    i_reset = 1'b1;
    #12;
    chk("rst_pc", o_PC, 32'h0);
    for (int r = 0; r < 32; r++) rdreg(r, 32'h0, $sformatf("rst_x%0d", r));

    @(posedge i_clk); #1;
    i_reset = 1'b0;
    idle();
    #1;
    chk("pc_after_release", o_PC, 32'h0);
    tick(); chk("pc_4", o_PC, 32'd4);
    tick(); chk("pc_8", o_PC, 32'd8);

    // addi x1,x0,1
    idle(); i_inst = 32'h00100093; i_ALUSrc = 1'b1; i_regWrite = 1'b1; #1;
    chk("addi1_alu", o_ALUOut, 32'd1);
    tick(); chk("pc_12", o_PC, 32'd12);
    rdreg(1, 32'd1, "x1_is_1");

    // addi x2,x0,-1
    idle(); i_inst = 32'hFFF00113; i_ALUSrc = 1'b1; i_regWrite = 1'b1; #1;
    chk("addim1_alu", o_ALUOut, 32'hFFFFFFFF);
    tick(); rdreg(2, 32'hFFFFFFFF, "x2_is_m1");

    // add x3,x1,x2
    idle(); i_inst = 32'h002081B3; i_regWrite = 1'b1; #1;
    chk("add_alu", o_ALUOut, 32'h0);
    chk("add_zero", 32'(o_zero), 32'd1);
    chk("add_neg", 32'(o_neg), 32'd0);
    chk("add_negU", 32'(o_negU), 32'd1);
    tick(); chk("pc_20", o_PC, 32'd20);
    rdreg(3, 32'h0, "x3_is_0");

    // lui x5,0x12345 via immPlus with zero base
    idle(); i_inst = 32'h123452B7; i_immSrc = IMM_U; i_immPlusSrc = 1'b1;
    i_resultSrc = RES_IMMPLUS; i_regWrite = 1'b1;
    tick(); rdreg(5, 32'h12345000, "lui_x5");

    // addi x1,x0,7
    idle(); i_inst = 32'h00700093; i_ALUSrc = 1'b1; i_regWrite = 1'b1;
    tick(); chk("pc_28", o_PC, 32'd28);

    // absolute jump to 8 through immPlus with zero base
    idle(); i_inst = 32'h00800013; i_immPlusSrc = 1'b1; i_PCSrc = PCSRC_IMMPLUS;
    tick(); chk("abs_jump_8", o_PC, 32'd8);

    // auipc x5,0x12345 at PC=8
    idle(); i_inst = 32'h123452B7; i_immSrc = IMM_U; i_resultSrc = RES_IMMPLUS; i_regWrite = 1'b1;
    tick(); chk("pc_after_auipc", o_PC, 32'd12);
    rdreg(5, 32'h12345008, "auipc_x5");

    // jalr x6,6(x1) at PC=12 with x1=7
    idle(); i_inst = 32'h00608367; i_ALUSrc = 1'b1; i_PCSrc = PCSRC_ALU;
    i_resultSrc = RES_PC4; i_regWrite = 1'b1; #1;
    chk("jalr_alu", o_ALUOut, 32'd13);
    tick(); chk("jalr_pc", o_PC, 32'd12);
    rdreg(6, 32'd16, "jalr_link");

    idle(); i_inst = 32'h00400013; i_immPlusSrc = 1'b1; i_PCSrc = PCSRC_IMMPLUS;
    tick(); chk("abs_jump_4", o_PC, 32'd4);

    // beq x0,x0,+8 at PC=4
    idle(); i_inst = 32'h00000463; i_immSrc = IMM_B; i_ALUCtrl = ALU_SUB; i_PCSrc = PCSRC_IMMPLUS; #1;
    chk("beq_zero", 32'(o_zero), 32'd1);
    tick(); chk("beq_pc", o_PC, 32'd12);

    // jal x0,+16 at PC=12
    idle(); i_inst = 32'h0100006F; i_immSrc = IMM_J; i_PCSrc = PCSRC_IMMPLUS;
    i_resultSrc = RES_PC4; i_regWrite = 1'b1;
    tick(); chk("jal_pc", o_PC, 32'd28);

    // loads
    idle(); i_inst = 32'h00200383; i_ALUSrc = 1'b1; #1;
    chk("load_addr", o_ALUOut, 32'd2);
    load_step(32'h00200383, MEM_B, 1'b1, 32'h12803456); rdreg(7,  32'hFFFFFF80, "lb_off2");
    load_step(32'h00200403, MEM_B, 1'b0, 32'h12803456); rdreg(8,  32'h00000080, "lbu_off2");
    load_step(32'h00200503, MEM_H, 1'b1, 32'h12803456); rdreg(10, 32'h00001280, "lh_off2");
    load_step(32'h00000583, MEM_H, 1'b1, 32'h12808001); rdreg(11, 32'hFFFF8001, "lh_off0");
    load_step(32'h00100603, MEM_B, 1'b1, 32'h12803456); rdreg(12, 32'h00000034, "lb_off1");
    load_step(32'h00000683, MEM_W, 1'b1, 32'h12803456); rdreg(13, 32'h12803456, "lw_off0");

    // addi x0,x0,5 must not stick
    idle(); i_inst = 32'h00500013; i_ALUSrc = 1'b1; i_regWrite = 1'b1;
    tick(); rdreg(0, 32'h0, "x0_stays_0");

    // x9 = 0xAABBCCDD via lui + addi
    idle(); i_inst = 32'hAABBD4B7; i_immSrc = IMM_U; i_immPlusSrc = 1'b1;
    i_resultSrc = RES_IMMPLUS; i_regWrite = 1'b1;
    tick();
    idle(); i_inst = 32'hCDD48493; i_ALUSrc = 1'b1; i_regWrite = 1'b1;
    tick(); rdreg(9, 32'hAABBCCDD, "x9_built");

    // stores of x9
    idle(); i_inst = 32'h00900023; i_ALUSrc = 1'b1; i_immSrc = IMM_S;
    i_memSize = MEM_B; #1; chk("sb_data", o_writeData, 32'hDDDDDDDD);
    i_memSize = MEM_H; #1; chk("sh_data", o_writeData, 32'hCCDDCCDD);
    i_memSize = MEM_W; #1; chk("sw_data", o_writeData, 32'hAABBCCDD);
    i_memSize = 2'b11; #1; chk("s11_data", o_writeData, 32'hAABBCCDD);

    // sw x9,-4(x1): S immediate sign extension
    idle(); i_inst = 32'hFE90AE23; i_ALUSrc = 1'b1; i_immSrc = IMM_S; #1;
    chk("s_imm_addr", o_ALUOut, 32'd3);

    // ALU ops with A=x9=0xAABBCCDD, B=x1=7
    for (int k = 0; k < 12; k++) begin
      idle(); i_inst = 32'h00148033; i_ALUCtrl = ops[k]; #1;
      chk($sformatf("alu_op%0h", ops[k]), o_ALUOut, expv[k]);
    end
    chk("flag_neg", 32'(o_neg), 32'd1);
    chk("flag_negU", 32'(o_negU), 32'd0);

    // asynchronous reset between edges with a pending write
    idle(); i_inst = 32'h00100093; i_ALUSrc = 1'b1; i_regWrite = 1'b1;
    #3;
    i_reset = 1'b1;
    #1;
    chk("midrst_pc", o_PC, 32'h0);
    tick();
    i_reset = 1'b0;
    rdreg(1, 32'h0, "midrst_x1");
    rdreg(9, 32'h0, "midrst_x9");
    chk("midrst_pc_held", o_PC, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
